clz_denorm: RTL and testbench

Iterative denormalizer: the inverse of the count-leading-zeros path. Given a normalized 32-bit word and a shift count in the same 5-bit format the Clz unit produces, it shifts the word right by that count, one bit per cycle. It also produces a sticky bit: the OR of every bit shifted out. It sits beside Clz in the execute stage, to restore operands for multi-cycle arithmetic, and as a round-trip checker for Clz in simulation.

---
 rtl/clz_denorm.sv | 96 +++++++++
 tb/tb_clz_denorm.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/clz_denorm.sv
// ============================================================================
// Module   : clz_denorm
// Purpose  : Iterative right-shift denormalizer (one bit per cycle) with sticky.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clz_denorm #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [4:0]       num,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             sticky
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [4:0]       cnt_q,   cnt_d;
  logic             acc_q,   acc_d;
  logic [WIDTH-1:0] result_q;
  logic             sticky_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (num == 5'd0) ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (cnt_q == 5'd1) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_SHIFT);
    done = (state_q == ST_DONE);
  end

  // Datapath next-state; start is only honoured in IDLE.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    if (state_q == ST_IDLE && start) begin
      shreg_d = data;
      cnt_d   = num;
      acc_d   = 1'b0;
    end else if (state_q == ST_SHIFT) begin
      shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
      cnt_d   = cnt_q - 5'd1;
      acc_d   = acc_q | shreg_q[0];
    end
  end

  // Outputs load from the datapath's next value on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q  <= '0;
      cnt_q    <= '0;
      acc_q    <= 1'b0;
      result_q <= '0;
      sticky_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      if (state_d == ST_DONE) begin
        result_q <= shreg_d;
        sticky_q <= acc_d;
      end
    end
  end

  assign result = result_q;
  assign sticky = sticky_q;

endmodule

`default_nettype wire

// File: tb/tb_clz_denorm.sv
// ============================================================================
// Module   : tb_clz_denorm
// Purpose  : Scoreboard bench for clz_denorm using directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clz_denorm;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] data;
  logic [4:0]  num;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        sticky;

  typedef struct {
    logic [31:0] res;
    logic        stk;
    int          busy_cycles;
    bit          clz_chk;
    int          n;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   busy_run = 0;

  clz_denorm #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .data(data), .num(num),
    .busy(busy), .done(done), .result(result), .sticky(sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clz32(input logic [31:0] v);
    int c = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) break;
      c++;
    end
    return c;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        chk(!busy, "busy_done_excl", {31'd0, busy}, 32'd0);
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk(result == e.res, "result", result, e.res);
          chk(sticky == e.stk, "sticky", {31'd0, sticky}, {31'd0, e.stk});
          chk(busy_run == e.busy_cycles, "busy_cycles", busy_run, e.busy_cycles);
          if (e.clz_chk)
            chk(clz32(result) == e.n, "clz_roundtrip", clz32(result), e.n);
        end
        busy_run = 0;
      end
    end
  end

  task automatic check_zero(input string tag);
    chk(busy == 1'b0,    {tag, "_busy"},   {31'd0, busy},   32'd0);
    chk(done == 1'b0,    {tag, "_done"},   {31'd0, done},   32'd0);
    chk(result == 32'd0, {tag, "_result"}, result,          32'd0);
    chk(sticky == 1'b0,  {tag, "_sticky"}, {31'd0, sticky}, 32'd0);
  endtask

  task automatic wait_drain(input string tag);
    int k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      chk(1'b0, {tag, "_timeout"}, sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  // Called 1ns after a posedge with the DUT in IDLE; returns likewise.
  task automatic run_op(input logic [31:0] d, input logic [4:0] n,
                        input logic [31:0] er, input logic es, input bit cc, input string tag);
    exp_t e;
    e.res = er; e.stk = es; e.busy_cycles = int'(n); e.clz_chk = cc; e.n = int'(n);
    sb.push_back(e);
    data = d; num = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    data  = $urandom;
    num   = 5'($urandom);
    wait_drain(tag);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; data = '0; num = '0;
    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      check_zero("reset");
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_zero("post_reset");
    end
    @(posedge clk); #1;

    run_op(32'hF000_0001, 5'd4,  32'h0F00_0000, 1'b1, 1'b0, "shift4");
    run_op(32'h8000_0000, 5'd0,  32'h8000_0000, 1'b0, 1'b1, "zero_cnt");
    run_op(32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 1'b1, 1'b0, "max_ones");
    run_op(32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 1'b1, "max_msb");
    run_op(32'h0000_0000, 5'd7,  32'h0000_0000, 1'b0, 1'b0, "zero_data");

    // Ignored starts: one during SHIFT, one during the DONE cycle.
    begin
      exp_t e;
      e.res = 32'h0004_8D15; e.stk = 1'b1; e.busy_cycles = 10; e.clz_chk = 1'b0; e.n = 10;
      sb.push_back(e);
    end
    data = 32'h1234_5678; num = 5'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 start = 1'b1; data = 32'hFFFF_FFFF; num = 5'd1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk(sb.size() == 0, "ignored_start_done_seen", sb.size(), 32'd0);
    chk(busy == 1'b0, "start_in_done_ignored", {31'd0, busy}, 32'd0);
    chk(result == 32'h0004_8D15, "result_held", result, 32'h0004_8D15);

    // Reset abort after two shift cycles.
    data = 32'hFFFF_FFFF; num = 5'd20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("abort");
    repeat (25) @(negedge clk);
    chk(done == 1'b0, "abort_no_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;

    // Clz round trip over every count.
    for (int n = 0; n < 32; n++) begin
      run_op(32'h8000_0000 | 32'(n), 5'(n), 32'h8000_0000 >> n, (n != 0), 1'b1, "roundtrip");
    end

    wait_drain("final");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
